// File: rtl/mul_hilo.sv
// HI/LO control and writeback stage behind the two-stage multiplier.
// Define MUL_HILO_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulation into HI/LO.
module mul_hilo #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        op_ready,
  input  logic        flush,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  output logic        mul_signed,
  input  logic [63:0] mul_result,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned DLEN = 2 * XLEN;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MTHI  = 3'd2;
  localparam logic [2:0] OP_MTLO  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MADDU = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;
  localparam logic [2:0] OP_MSUBU = 3'd7;

  typedef enum logic [1:0] {
    KIND_PLAIN = 2'd0,
    KIND_ADD   = 2'd1,
    KIND_SUB   = 2'd2
  } kind_e;

  typedef struct packed {
    logic  valid;
    kind_e kind;
  } trk_t;

`ifdef MUL_HILO_MADD_EN
  localparam kind_e ACC_ADD_KIND = KIND_ADD;
  localparam kind_e ACC_SUB_KIND = KIND_SUB;
`else
  localparam kind_e ACC_ADD_KIND = KIND_PLAIN;
  localparam kind_e ACC_SUB_KIND = KIND_PLAIN;
`endif

  logic            dec_mul;
  logic            dec_mthi;
  logic            dec_mtlo;
  logic            dec_signed;
  kind_e           dec_kind;
  logic            accept;
  trk_t            trk_q [MUL_LAT];
  trk_t            trk_in;
  trk_t            wb;
  logic [DLEN-1:0] hilo_q;
  logic [DLEN-1:0] hilo_d;
  logic [DLEN-1:0] wb_val;

  // Opcode decode into multiply/move class, signedness and accumulate kind.
  always_comb begin
    dec_mul    = 1'b0;
    dec_mthi   = 1'b0;
    dec_mtlo   = 1'b0;
    dec_signed = 1'b0;
    dec_kind   = KIND_PLAIN;
    case (op_code)
      OP_MULT:  begin dec_mul = 1'b1; dec_signed = 1'b1; end
      OP_MULTU: dec_mul = 1'b1;
      OP_MTHI:  dec_mthi = 1'b1;
      OP_MTLO:  dec_mtlo = 1'b1;
      OP_MADD:  begin dec_mul = 1'b1; dec_signed = 1'b1; dec_kind = ACC_ADD_KIND; end
      OP_MADDU: begin dec_mul = 1'b1; dec_kind = ACC_ADD_KIND; end
      OP_MSUB:  begin dec_mul = 1'b1; dec_signed = 1'b1; dec_kind = ACC_SUB_KIND; end
      OP_MSUBU: begin dec_mul = 1'b1; dec_kind = ACC_SUB_KIND; end
      default:  ;
    endcase
  end

  assign mul_x      = op_a;
  assign mul_y      = op_b;
  assign mul_signed = resetn & dec_signed;

  // Moves wait for in-flight products so an older product cannot clobber them.
  assign op_ready = ~flush & ~((dec_mthi | dec_mtlo) & busy);
  assign accept   = op_valid & op_ready;

  always_comb begin
    trk_in       = '0;
    trk_in.valid = accept & dec_mul;
    trk_in.kind  = dec_kind;
  end

  // Tracker shift, one stage per multiplier pipeline register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(MUL_LAT); i++) trk_q[i] <= '0;
    end else begin
      trk_q[0] <= flush ? '0 : trk_in;
      for (int i = 1; i < int'(MUL_LAT); i++) trk_q[i] <= flush ? '0 : trk_q[i-1];
    end
  end

  assign wb = trk_q[MUL_LAT-1];

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < int'(MUL_LAT); i++) busy = busy | trk_q[i].valid;
  end

  // Writeback value; accumulate forms read the HI/LO written on the previous edge.
  always_comb begin
    wb_val = mul_result;
    case (wb.kind)
`ifdef MUL_HILO_MADD_EN
      KIND_ADD: wb_val = DLEN'(hilo_q + mul_result);
      KIND_SUB: wb_val = DLEN'(hilo_q - mul_result);
`endif
      default:  wb_val = mul_result;
    endcase
  end

  always_comb begin
    hilo_d = hilo_q;
    if (wb.valid && !flush) begin
      hilo_d = wb_val;
    end else if (accept && dec_mthi) begin
      hilo_d[DLEN-1:XLEN] = op_a;
    end else if (accept && dec_mtlo) begin
      hilo_d[XLEN-1:0] = op_a;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) hilo_q <= '0;
    else         hilo_q <= hilo_d;
  end

  assign hi = hilo_q[DLEN-1:XLEN];
  assign lo = hilo_q[XLEN-1:0];

endmodule

// File: tb/tb_mul_hilo.sv
// Directed self-checking bench for mul_hilo with a behavioural two-stage multiplier.
module tb_mul_hilo;

  logic        clk;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_ready;
  logic        flush;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic        mul_signed;
  logic [63:0] mul_result;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  mul_hilo #(.MUL_LAT(2)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .op_ready(op_ready), .flush(flush),
    .mul_x(mul_x), .mul_y(mul_y), .mul_signed(mul_signed),
    .mul_result(mul_result), .hi(hi), .lo(lo), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: operands sampled every edge, product valid two edges later.
  logic [63:0] xe, ye, p1, p2;
  assign xe = mul_signed ? {{32{mul_x[31]}}, mul_x} : {32'b0, mul_x};
  assign ye = mul_signed ? {{32{mul_y[31]}}, mul_y} : {32'b0, mul_y};
  always @(posedge clk) begin
    p1 <= xe * ye;
    p2 <= p1;
  end
  assign mul_result = p2;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    op_valid = v; op_code = c; op_a = a; op_b = b;
  endtask

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0;
    drive(1'b0, 3'd0, 32'hDEADBEEF, 32'h0BADF00D);
    tick(); #1;
    n_checks++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", hi); else n_pass++;
    n_checks++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", lo); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (mul_signed !== 1'b0) $display("FAIL reset_mul_signed: got %b want 0", mul_signed); else n_pass++;
    n_checks++; if (op_ready !== 1'b1) $display("FAIL reset_op_ready: got %b want 1", op_ready); else n_pass++;
    n_checks++; if (mul_x !== 32'hDEADBEEF) $display("FAIL reset_mul_x: got %h want deadbeef", mul_x); else n_pass++;
    n_checks++; if (mul_y !== 32'h0BADF00D) $display("FAIL reset_mul_y: got %h want 0badf00d", mul_y); else n_pass++;
    tick();
    resetn = 1'b1;
    drive(1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  task automatic test_decode();
    logic exp_sig;
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 3'(c), 32'h0, 32'h0);
      exp_sig = (c == 0) || (c == 4) || (c == 6);
      #1;
      n_checks++; if (mul_signed !== exp_sig) $display("FAIL decode_signed code %0d: got %b want %b", c, mul_signed, exp_sig); else n_pass++;
    end
    drive(1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  task automatic test_mult();
    tick(); drive(1'b1, 3'd0, 32'hFFFFFFFF, 32'h00000002); #1;
    n_checks++; if (op_ready !== 1'b1) $display("FAIL mult_ready: got %b want 1", op_ready); else n_pass++;
    tick(); drive(1'b0, 3'd0, 32'h0, 32'h0); #1;
    n_checks++; if (busy !== 1'b1) $display("FAIL mult_busy_c1: got %b want 1", busy); else n_pass++;
    tick(); #1;
    n_checks++; if (busy !== 1'b1) $display("FAIL mult_busy_c2: got %b want 1", busy); else n_pass++;
    n_checks++; if (lo !== 32'h0) $display("FAIL mult_lo_c2: got %h want 0", lo); else n_pass++;
    tick(); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL mult_busy_c3: got %b want 0", busy); else n_pass++;
    n_checks++; if (hi !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h want ffffffff", hi); else n_pass++;
    n_checks++; if (lo !== 32'hFFFFFFFE) $display("FAIL mult_lo: got %h want fffffffe", lo); else n_pass++;
  endtask

  task automatic test_multu();
    tick(); drive(1'b1, 3'd1, 32'hFFFFFFFF, 32'h00000002); #1;
    n_checks++; if (mul_signed !== 1'b0) $display("FAIL multu_signed: got %b want 0", mul_signed); else n_pass++;
    tick(); drive(1'b0, 3'd0, 32'h0, 32'h0);
    tick(); #1;
    n_checks++; if (hi !== 32'hFFFFFFFF) $display("FAIL multu_hi_c2: got %h want ffffffff", hi); else n_pass++;
    tick(); #1;
    n_checks++; if (hi !== 32'h00000001) $display("FAIL multu_hi: got %h want 00000001", hi); else n_pass++;
    n_checks++; if (lo !== 32'hFFFFFFFE) $display("FAIL multu_lo: got %h want fffffffe", lo); else n_pass++;
  endtask

  task automatic test_back_to_back();
    tick(); drive(1'b1, 3'd0, 32'd3, 32'd4);
    tick(); drive(1'b1, 3'd0, 32'd5, 32'd6); #1;
    n_checks++; if (op_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", op_ready); else n_pass++;
    tick(); drive(1'b0, 3'd0, 32'h0, 32'h0);
    tick(); #1;
    n_checks++; if (lo !== 32'd12) $display("FAIL b2b_lo_c3: got %0d want 12", lo); else n_pass++;
    n_checks++; if (hi !== 32'd0) $display("FAIL b2b_hi_c3: got %h want 0", hi); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL b2b_busy_c3: got %b want 1", busy); else n_pass++;
    tick(); #1;
    n_checks++; if (lo !== 32'd30) $display("FAIL b2b_lo_c4: got %0d want 30", lo); else n_pass++;
    n_checks++; if (hi !== 32'd0) $display("FAIL b2b_hi_c4: got %h want 0", hi); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_busy_c4: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_move_stall();
    tick(); drive(1'b1, 3'd0, 32'd2, 32'd8);
    tick(); drive(1'b1, 3'd2, 32'h00001234, 32'h0); #1;
    n_checks++; if (op_ready !== 1'b0) $display("FAIL mthi_ready_c1: got %b want 0", op_ready); else n_pass++;
    tick(); #1;
    n_checks++; if (op_ready !== 1'b0) $display("FAIL mthi_ready_c2: got %b want 0", op_ready); else n_pass++;
    tick(); #1;
    n_checks++; if (op_ready !== 1'b1) $display("FAIL mthi_ready_c3: got %b want 1", op_ready); else n_pass++;
    n_checks++; if (lo !== 32'd16) $display("FAIL mthi_lo_c3: got %0d want 16", lo); else n_pass++;
    n_checks++; if (hi !== 32'h0) $display("FAIL mthi_hi_c3: got %h want 0", hi); else n_pass++;
    tick(); drive(1'b1, 3'd3, 32'h0000CAFE, 32'h0); #1;
    n_checks++; if (hi !== 32'h00001234) $display("FAIL mthi_hi_c4: got %h want 00001234", hi); else n_pass++;
    n_checks++; if (op_ready !== 1'b1) $display("FAIL mtlo_ready: got %b want 1", op_ready); else n_pass++;
    tick(); drive(1'b0, 3'd0, 32'h0, 32'h0); #1;
    n_checks++; if (lo !== 32'h0000CAFE) $display("FAIL mtlo_lo: got %h want 0000cafe", lo); else n_pass++;
    n_checks++; if (hi !== 32'h00001234) $display("FAIL mtlo_hi: got %h want 00001234", hi); else n_pass++;
  endtask

  task automatic test_flush();
    tick(); drive(1'b1, 3'd0, 32'd7, 32'd7);
    tick(); drive(1'b1, 3'd3, 32'h00009999, 32'h0); flush = 1'b1; #1;
    n_checks++; if (op_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", op_ready); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL flush_busy_c1: got %b want 1", busy); else n_pass++;
    tick(); drive(1'b0, 3'd0, 32'h0, 32'h0); flush = 1'b0; #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL flush_busy_c2: got %b want 0", busy); else n_pass++;
    n_checks++; if (lo !== 32'h0000CAFE) $display("FAIL flush_mtlo_blocked: got %h want 0000cafe", lo); else n_pass++;
    tick(); tick(); #1;
    n_checks++; if (lo !== 32'h0000CAFE) $display("FAIL flush_lo_c4: got %h want 0000cafe", lo); else n_pass++;
    n_checks++; if (hi !== 32'h00001234) $display("FAIL flush_hi_c4: got %h want 00001234", hi); else n_pass++;
    // flush coinciding with the writeback edge
    tick(); drive(1'b1, 3'd0, 32'd7, 32'd7);
    tick(); drive(1'b0, 3'd0, 32'h0, 32'h0);
    tick(); flush = 1'b1; #1;
    n_checks++; if (busy !== 1'b1) $display("FAIL flush_wb_busy_c2: got %b want 1", busy); else n_pass++;
    tick(); flush = 1'b0; #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL flush_wb_busy_c3: got %b want 0", busy); else n_pass++;
    n_checks++; if (lo !== 32'h0000CAFE) $display("FAIL flush_wb_lo: got %h want 0000cafe", lo); else n_pass++;
    n_checks++; if (hi !== 32'h00001234) $display("FAIL flush_wb_hi: got %h want 00001234", hi); else n_pass++;
  endtask

  task automatic test_reset_mid();
    tick(); drive(1'b1, 3'd0, 32'd7, 32'd7);
    tick(); drive(1'b0, 3'd0, 32'h0, 32'h0); resetn = 1'b0; #1;
    n_checks++; if (hi !== 32'h0) $display("FAIL rstmid_hi: got %h want 0", hi); else n_pass++;
    n_checks++; if (lo !== 32'h0) $display("FAIL rstmid_lo: got %h want 0", lo); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
    tick(); resetn = 1'b1;
    tick(); tick(); #1;
    n_checks++; if (lo !== 32'h0) $display("FAIL rstmid_lo_after: got %h want 0", lo); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy_after: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_madd();
    logic [31:0] exp_hi, exp_lo;
    tick(); drive(1'b1, 3'd2, 32'h0, 32'h0);
    tick(); drive(1'b1, 3'd3, 32'hFFFFFFFF, 32'h0);
    tick(); drive(1'b1, 3'd5, 32'd1, 32'd1); #1;
    n_checks++; if (mul_signed !== 1'b0) $display("FAIL maddu_signed: got %b want 0", mul_signed); else n_pass++;
    n_checks++; if (op_ready !== 1'b1) $display("FAIL maddu_ready: got %b want 1", op_ready); else n_pass++;
    tick(); drive(1'b0, 3'd0, 32'h0, 32'h0);
    tick(); tick(); #1;
`ifdef MUL_HILO_MADD_EN
    exp_hi = 32'h1; exp_lo = 32'h0;
`else
    exp_hi = 32'h0; exp_lo = 32'h1;
`endif
    n_checks++; if (hi !== exp_hi) $display("FAIL maddu_hi: got %h want %h", hi, exp_hi); else n_pass++;
    n_checks++; if (lo !== exp_lo) $display("FAIL maddu_lo: got %h want %h", lo, exp_lo); else n_pass++;
    tick(); drive(1'b1, 3'd6, 32'hFFFFFFFF, 32'd1); #1;
    n_checks++; if (mul_signed !== 1'b1) $display("FAIL msub_signed: got %b want 1", mul_signed); else n_pass++;
    tick(); drive(1'b0, 3'd0, 32'h0, 32'h0);
    tick(); tick(); #1;
`ifdef MUL_HILO_MADD_EN
    exp_hi = 32'h1; exp_lo = 32'h1;
`else
    exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFFF;
`endif
    n_checks++; if (hi !== exp_hi) $display("FAIL msub_hi: got %h want %h", hi, exp_hi); else n_pass++;
    n_checks++; if (lo !== exp_lo) $display("FAIL msub_lo: got %h want %h", lo, exp_lo); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; flush = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    test_reset();
    test_decode();
    test_mult();
    test_multu();
    test_back_to_back();
    test_move_stall();
    test_flush();
    test_reset_mid();
    test_madd();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
